// File: rtl/aes_perm_pkg.sv
// Shared constants, state encoding and word helpers for the bit-permuted MixColumn stage.
package aes_perm_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned NWORDS  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic PERM_FWD = 1'b0;
    localparam logic PERM_INV = 1'b1;

    // Word 0 is the most-significant 32 bits of the state.
    function automatic logic [WORD_W-1:0] get_word(input logic [STATE_W-1:0] s,
                                                   input logic [1:0]         i);
        logic [WORD_W-1:0] w;
        unique case (i)
            2'd0:    w = s[127:96];
            2'd1:    w = s[95:64];
            2'd2:    w = s[63:32];
            default: w = s[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [STATE_W-1:0] set_word(input logic [STATE_W-1:0] s,
                                                    input logic [1:0]         i,
                                                    input logic [WORD_W-1:0]  w);
        logic [STATE_W-1:0] r;
        r = s;
        unique case (i)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/word_perm.sv
// Combinational 32-bit bit permuter: 4x8 <-> 8x4 bit transpose, selectable direction.
module word_perm
    import aes_perm_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    input  logic              inv,
    output logic [WORD_W-1:0] word_out_c
);

    logic [WORD_W-1:0] fwd_w;
    logic [WORD_W-1:0] inv_w;

    always_comb begin
        fwd_w = '0;
        inv_w = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                inv_w[31-(8*r+c)] = word_in[31-(r+4*c)];
                fwd_w[31-(r+4*c)] = word_in[31-(8*r+c)];
            end
        end
        word_out_c = (inv == PERM_INV) ? inv_w : fwd_w;
    end

endmodule

// File: rtl/bit_perm_ctrl.sv
// Sequences a 128-bit state through LANES shared word permuters, MS word first,
// and hands the result off over a valid/ready interface.
module bit_perm_ctrl
    import aes_perm_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [STATE_W-1:0] in_data,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    localparam logic [1:0] LAST_IDX = 2'(NWORDS - LANES);
    localparam logic [1:0] IDX_STEP = 2'(LANES);

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [STATE_W-1:0] blk_q, blk_d;
    logic               inv_q, inv_d;
    logic [STATE_W-1:0] acc_q, acc_d;
    logic [STATE_W-1:0] out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [WORD_W-1:0]  lane_out [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        word_perm u_word_perm (
            .word_in    (get_word(blk_q, idx_q + 2'(g))),
            .inv        (inv_q),
            .word_out_c (lane_out[g])
        );
    end

    // Accept in IDLE, or in DONE in the same cycle the result is taken.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        blk_d      = blk_q;
        inv_d      = inv_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = in_data;
                    inv_d   = in_inv;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        acc_d = set_word(acc_d, idx_q + 2'(l), lane_out[l]);
                    end
                    if (idx_q == LAST_IDX) begin
                        out_data_d = acc_d;
                        idx_d      = '0;
                        state_d    = DONE;
                    end else begin
                        idx_d = idx_q + IDX_STEP;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        blk_d   = in_data;
                        inv_d   = in_inv;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            blk_q       <= '0;
            inv_q       <= PERM_FWD;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            blk_q       <= blk_d;
            inv_q       <= inv_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
